// File: rtl/io_bus_pkg.sv
// Shared types and constants for the I/O board bus scheduler.
package io_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } bus_state_t;

   localparam logic [1:0] ENABLE_IDLE = 2'b11;
   localparam logic [1:0] ENABLE_GRP0 = 2'b10;
   localparam logic [1:0] ENABLE_GRP1 = 2'b01;

   // Width of the per-state slot timer.
   localparam int TIMER_W = 8;

   // Register bit 3 selects which board group's active-low enable is pulled.
   function automatic logic [1:0] enable_code(input logic [3:0] reg_num);
      return reg_num[3] ? ENABLE_GRP1 : ENABLE_GRP0;
   endfunction

endpackage

// File: rtl/io_slot_timer.sv
// Per-state down-counter: loaded with (cycles-1) on entry to a timed state,
// done is high on the last cycle of that state.
module io_slot_timer
   import io_bus_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load takes priority; otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == '0);

endmodule

// File: rtl/io_bus_scheduler.sv
// I/O board bus scheduler: arbitrates a background scanner against host
// single-register accesses and sequences setup/strobe/hold on the bus.
// Optional macro IO_INPUT_CHANGE_EN adds in_changed / in_changed_reg.
//
// state  | meaning
// IDLE   | bus quiet, arbitration decided here
// SETUP  | address/data valid, enables still high
// STROBE | board-group enable low; read data sampled on last cycle
// HOLD   | enables high, address/data held, host_ack pulses
module io_bus_scheduler
   import io_bus_pkg::*;
#(
   parameter int BOARDS           = 16,
   parameter int INSTALLED_BOARDS = 2,
   parameter int SETUP_CYCLES     = 1,
   parameter int STROBE_CYCLES    = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  scan_en,
   input  logic [BOARDS*8-1:0]   outputs,
   output logic [BOARDS*8-1:0]   inputs,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [3:0]            host_reg,
   input  logic [7:0]            host_wdata,
   output logic                  host_ack,
   output logic [7:0]            host_rdata,
   output logic [3:0]            io_address,
   output logic [1:0]            io_enable_n,
   output logic [7:0]            io_data_out,
   output logic                  io_data_oe,
   input  logic [7:0]            io_data_in,
   output logic                  busy
`ifdef IO_INPUT_CHANGE_EN
   ,
   output logic                  in_changed,
   output logic [3:0]            in_changed_reg
`endif
);

   localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(SETUP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(STROBE_CYCLES - 1);
   localparam logic [3:0]         LAST_PTR    = 4'(INSTALLED_BOARDS - 1);
   localparam logic [4:0]         INST_COUNT  = 5'(INSTALLED_BOARDS);

   bus_state_t            state_q, state_d;
   logic [3:0]            slot_reg_q, slot_reg_d;
   logic                  slot_we_q, slot_we_d;
   logic                  slot_host_q, slot_host_d;
   logic                  last_host_q, last_host_d;
   logic [3:0]            scan_ptr_q, scan_ptr_d;
   logic                  scan_phase_q, scan_phase_d;
   logic [3:0]            io_address_q, io_address_d;
   logic [1:0]            io_enable_q, io_enable_d;
   logic [7:0]            io_data_out_q, io_data_out_d;
   logic                  io_data_oe_q, io_data_oe_d;
   logic [BOARDS*8-1:0]   inputs_q, inputs_d;
   logic                  host_ack_q, host_ack_d;
   logic [7:0]            host_rdata_q, host_rdata_d;
`ifdef IO_INPUT_CHANGE_EN
   logic                  in_changed_q, in_changed_d;
   logic [3:0]            in_changed_reg_q, in_changed_reg_d;
`endif

   logic                  timer_load;
   logic [TIMER_W-1:0]    timer_val;
   logic                  timer_done;
   logic                  host_installed;
   logic                  take_host;

   io_slot_timer #(.W(TIMER_W)) u_timer (
      .Clk      (Clk),
      .Rst      (Rst),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Right after a host slot the scanner gets one turn so it cannot starve.
   assign host_installed = ({1'b0, host_reg} < INST_COUNT);
   assign take_host      = host_req && !(last_host_q && scan_en);

   // Next-state, slot capture, timer control and bus output decode.
   always_comb begin
      state_d       = state_q;
      slot_reg_d    = slot_reg_q;
      slot_we_d     = slot_we_q;
      slot_host_d   = slot_host_q;
      last_host_d   = last_host_q;
      scan_ptr_d    = scan_ptr_q;
      scan_phase_d  = scan_phase_q;
      io_address_d  = io_address_q;
      io_data_out_d = io_data_out_q;
      io_data_oe_d  = io_data_oe_q;
      inputs_d      = inputs_q;
      host_ack_d    = 1'b0;
      host_rdata_d  = host_rdata_q;
      timer_load    = 1'b0;
      timer_val     = SETUP_LOAD;
`ifdef IO_INPUT_CHANGE_EN
      in_changed_d     = 1'b0;
      in_changed_reg_d = in_changed_reg_q;
`endif

      case (state_q)
         IDLE: begin
            if (take_host) begin
               last_host_d = 1'b1;
               slot_host_d = 1'b1;
               if (host_installed) begin
                  state_d      = SETUP;
                  slot_reg_d   = host_reg;
                  slot_we_d    = host_we;
                  io_address_d = {host_we, host_reg[2:0]};
                  timer_load   = 1'b1;
                  if (host_we) begin
                     io_data_out_d = host_wdata;
                     io_data_oe_d  = 1'b1;
                  end
               end else begin
                  // Absent board: complete without touching the bus.
                  state_d      = HOLD;
                  host_ack_d   = 1'b1;
                  host_rdata_d = 8'hFF;
               end
            end else if (scan_en) begin
               state_d      = SETUP;
               last_host_d  = 1'b0;
               slot_host_d  = 1'b0;
               slot_reg_d   = scan_ptr_q;
               slot_we_d    = ~scan_phase_q;
               io_address_d = {~scan_phase_q, scan_ptr_q[2:0]};
               timer_load   = 1'b1;
               if (!scan_phase_q) begin
                  io_data_out_d = outputs[{scan_ptr_q, 3'b000} +: 8];
                  io_data_oe_d  = 1'b1;
                  scan_phase_d  = 1'b1;
               end else begin
                  scan_phase_d = 1'b0;
                  scan_ptr_d   = (scan_ptr_q == LAST_PTR) ? 4'd0 : scan_ptr_q + 4'd1;
               end
            end
         end
         SETUP: begin
            if (timer_done) begin
               state_d    = STROBE;
               timer_load = 1'b1;
               timer_val  = STROBE_LOAD;
            end
         end
         STROBE: begin
            if (timer_done) begin
               state_d    = HOLD;
               host_ack_d = slot_host_q;
               if (!slot_we_q) begin
                  inputs_d[{slot_reg_q, 3'b000} +: 8] = io_data_in;
                  if (slot_host_q) begin
                     host_rdata_d = io_data_in;
                  end
`ifdef IO_INPUT_CHANGE_EN
                  if (io_data_in != inputs_q[{slot_reg_q, 3'b000} +: 8]) begin
                     in_changed_d     = 1'b1;
                     in_changed_reg_d = slot_reg_q;
                  end
`endif
               end
            end
         end
         HOLD: begin
            state_d      = IDLE;
            io_data_oe_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      io_enable_d = (state_d == STROBE) ? enable_code(slot_reg_q) : ENABLE_IDLE;
   end

   // State and registered bus/host outputs; reset aborts any slot in flight.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= IDLE;
         slot_reg_q    <= 4'd0;
         slot_we_q     <= 1'b0;
         slot_host_q   <= 1'b0;
         last_host_q   <= 1'b0;
         scan_ptr_q    <= 4'd0;
         scan_phase_q  <= 1'b0;
         io_address_q  <= 4'd0;
         io_enable_q   <= ENABLE_IDLE;
         io_data_out_q <= 8'd0;
         io_data_oe_q  <= 1'b0;
         inputs_q      <= '0;
         host_ack_q    <= 1'b0;
         host_rdata_q  <= 8'd0;
      end else begin
         state_q       <= state_d;
         slot_reg_q    <= slot_reg_d;
         slot_we_q     <= slot_we_d;
         slot_host_q   <= slot_host_d;
         last_host_q   <= last_host_d;
         scan_ptr_q    <= scan_ptr_d;
         scan_phase_q  <= scan_phase_d;
         io_address_q  <= io_address_d;
         io_enable_q   <= io_enable_d;
         io_data_out_q <= io_data_out_d;
         io_data_oe_q  <= io_data_oe_d;
         inputs_q      <= inputs_d;
         host_ack_q    <= host_ack_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

`ifdef IO_INPUT_CHANGE_EN
   // Change-detect pulse registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         in_changed_q     <= 1'b0;
         in_changed_reg_q <= 4'd0;
      end else begin
         in_changed_q     <= in_changed_d;
         in_changed_reg_q <= in_changed_reg_d;
      end
   end

   assign in_changed     = in_changed_q;
   assign in_changed_reg = in_changed_reg_q;
`endif

   assign inputs      = inputs_q;
   assign host_ack    = host_ack_q;
   assign host_rdata  = host_rdata_q;
   assign io_address  = io_address_q;
   assign io_enable_n = io_enable_q;
   assign io_data_out = io_data_out_q;
   assign io_data_oe  = io_data_oe_q;
   assign busy        = (state_q != IDLE);

endmodule
